sync_debouncer: RTL

SYNC_DEBOUNCER -- requirements
Module: sync_debouncer

---
 rtl/debounce_pkg.sv | 11 +
 rtl/ff_back_to_back.sv | 24 ++
 rtl/sync_debouncer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// FSM state encoding shared by the debouncer block.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      CHECK_HIGH  = 2'd1,
      STABLE_HIGH = 2'd2,
      CHECK_LOW   = 2'd3
   } debounce_state_e;

endpackage

// File: rtl/ff_back_to_back.sv
// Enable-gated shift synchronizer; latency NumStages enabled edges, no backpressure.
module ff_back_to_back #(
   parameter int NumStages = 2
) (
   input  logic clk_i,
   input  logic arst_ni,
   input  logic en_i,
   input  logic d_i,
   output logic q_o
);

   logic [NumStages-1:0] r_sync;

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_sync <= '0;
      end else if (en_i) begin
         r_sync <= {r_sync[NumStages-2:0], d_i};
      end
   end

   assign q_o = r_sync[NumStages-1];

endmodule

// File: rtl/sync_debouncer.sv
// Synchronize and debounce a bouncy level; q_o moves NumSyncStages+StableCycles enabled
// edges after a clean change, with registered one-cycle rise/fall pulses; en_i=0 freezes.
module sync_debouncer
   import debounce_pkg::*;
#(
   parameter int NumSyncStages = 2,
   parameter int StableCycles  = 16
) (
   input  logic clk_i,
   input  logic arst_ni,
   input  logic en_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CntW = $clog2(StableCycles + 1);
   // Count value on which the next still-different sample commits.
   localparam logic [CntW-1:0] LastCnt = CntW'(StableCycles - 1);

   logic            w_s;
   debounce_state_e r_state, w_state_nxt;
   logic [CntW-1:0] r_cnt, w_cnt_nxt;
   logic            r_q, w_q_nxt;
   logic            r_rise, w_rise_nxt;
   logic            r_fall, w_fall_nxt;

   ff_back_to_back #(
      .NumStages (NumSyncStages)
   ) u_sync (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .en_i    (en_i),
      .d_i     (d_i),
      .q_o     (w_s)
   );

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_state <= STABLE_LOW;
         r_cnt   <= '0;
         r_q     <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_q     <= w_q_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      if (en_i) begin
         unique case (r_state)
            STABLE_LOW: begin
               w_cnt_nxt = '0;
               if (w_s) begin
                  if (StableCycles == 1) begin
                     w_state_nxt = STABLE_HIGH;
                     w_rise_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = CHECK_HIGH;
                     w_cnt_nxt   = CntW'(1);
                  end
               end
            end
            CHECK_HIGH: begin
               if (!w_s) begin
                  w_state_nxt = STABLE_LOW;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == LastCnt) begin
                  w_state_nxt = STABLE_HIGH;
                  w_cnt_nxt   = '0;
                  w_rise_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            STABLE_HIGH: begin
               w_cnt_nxt = '0;
               if (!w_s) begin
                  if (StableCycles == 1) begin
                     w_state_nxt = STABLE_LOW;
                     w_fall_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = CHECK_LOW;
                     w_cnt_nxt   = CntW'(1);
                  end
               end
            end
            CHECK_LOW: begin
               if (w_s) begin
                  w_state_nxt = STABLE_HIGH;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == LastCnt) begin
                  w_state_nxt = STABLE_LOW;
                  w_cnt_nxt   = '0;
                  w_fall_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = STABLE_LOW;
               w_cnt_nxt   = '0;
            end
         endcase
      end
      // The debounced level is high while committed high, including while checking for low.
      w_q_nxt = (w_state_nxt == STABLE_HIGH) || (w_state_nxt == CHECK_LOW);
   end

   assign q_o    = r_q;
   assign rise_o = r_rise;
   assign fall_o = r_fall;

endmodule
